pingpong_swap_buffer: RTL and testbench

PINGPONG_SWAP_BUFFER -- requirements
Module: pingpong_swap_buffer

---
 rtl/pingpong_swap_buffer.sv | 106 ++++++++++
 tb/tb_pingpong_swap_buffer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/pingpong_swap_buffer.sv
// Two-bank ping-pong buffer: the writer fills one bank while the reader drains the other. Optional swap_count port under `PINGPONG_SWAP_COUNT_EN.
// Latency: a full write bank swaps one edge after its last write if the read bank is empty. Read data is combinational from the read bank.
// Backpressure: wr_ready is low while the write bank is full. rd_valid is low once the read bank is drained or before the first swap.
module pingpong_swap_buffer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_valid,
    input  logic [WIDTH-1:0] wr_data,
    output logic             wr_ready,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    input  logic             rd_ready,
    output logic             wr_bank,
    output logic             swap_pulse
`ifdef PINGPONG_SWAP_COUNT_EN
    ,
    output logic [15:0]      swap_count
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    // Both banks in one array, addressed by {bank, pointer}.
    logic [WIDTH-1:0] mem [2*DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          wr_full;   // write bank holds DEPTH words
    logic          rd_full;   // read bank still has unread words
    logic          rd_bank;
    logic          wr_fire;
    logic          rd_fire;
    logic          swap;

    assign rd_bank  = ~wr_bank;
    // Held low during reset so the writer sees no room while the block is cleared.
    assign wr_ready = ~rst & ~wr_full;
    assign rd_valid = rd_full;
    assign wr_fire  = wr_valid & wr_ready;
    assign rd_fire  = rd_valid & rd_ready;
    // Both operands are registered state, so the swap decision never sees same-cycle handshakes.
    assign swap     = wr_full & ~rd_full;
    assign rd_data  = rd_valid ? mem[{rd_bank, rd_ptr}] : '0;

    // Bank storage: written only through the write handshake; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[{wr_bank, wr_ptr}] <= wr_data;
        end
    end

    // Pointers, fill flags, bank ownership and the swap pulse.
    // A swap cannot coincide with either handshake: wr_ready is low while the write bank is full,
    // and rd_valid is low while the read bank is empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_bank    <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            wr_full    <= 1'b0;
            rd_full    <= 1'b0;
            swap_pulse <= 1'b0;
        end else begin
            swap_pulse <= swap;
            if (swap) begin
                wr_bank <= ~wr_bank;
                wr_ptr  <= '0;
                wr_full <= 1'b0;
                rd_ptr  <= '0;
                rd_full <= 1'b1;
            end else begin
                if (wr_fire) begin
                    wr_ptr <= wr_ptr + PW'(1);
                    if (wr_ptr == LAST) begin
                        wr_full <= 1'b1;
                    end
                end
                if (rd_fire) begin
                    rd_ptr <= rd_ptr + PW'(1);
                    if (rd_ptr == LAST) begin
                        rd_full <= 1'b0;
                    end
                end
            end
        end
    end

`ifdef PINGPONG_SWAP_COUNT_EN
    logic [15:0] swap_cnt;

    assign swap_count = swap_cnt;

    // Completed-swap counter; wraps naturally at 16 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            swap_cnt <= '0;
        end else if (swap) begin
            swap_cnt <= swap_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pingpong_swap_buffer.sv
// Bench for pingpong_swap_buffer: directed scenarios plus random traffic, checked against a queue model.
// Every cycle the outputs are compared with the model; read streams are also compared with the accepted writes.
// The model is purely behavioural: a write-bank queue, a read-bank queue and a bank index.
module tb_pingpong_swap_buffer;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic             clk      = 1'b0;
    logic             rst      = 1'b1;
    logic             wr_valid = 1'b0;
    logic [WIDTH-1:0] wr_data  = '0;
    logic             rd_ready = 1'b0;
    logic             wr_ready;
    logic             rd_valid;
    logic [WIDTH-1:0] rd_data;
    logic             wr_bank;
    logic             swap_pulse;
`ifdef PINGPONG_SWAP_COUNT_EN
    logic [15:0]      swap_count;
`endif

    pingpong_swap_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .rd_ready   (rd_ready),
        .wr_bank    (wr_bank),
        .swap_pulse (swap_pulse)
`ifdef PINGPONG_SWAP_COUNT_EN
        ,
        .swap_count (swap_count)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state.
    logic [WIDTH-1:0] m_wq[$];     // words sitting in the write bank
    logic [WIDTH-1:0] m_rq[$];     // words still to be read from the read bank
    bit               m_bank;
    bit               m_pulse;
    logic [15:0]      m_swaps;
    bit               last_wacc;

    logic [WIDTH-1:0] in_log[$];   // words accepted by the writer side
    logic [WIDTH-1:0] out_log[$];  // words observed leaving the reader side
    logic [WIDTH-1:0] exp_log[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        m_wq.delete();
        m_rq.delete();
        m_bank  = 1'b0;
        m_pulse = 1'b0;
        m_swaps = '0;
        in_log.delete();
        out_log.delete();
    endtask

    task automatic check_outputs();
        chk("wr_ready",   32'(wr_ready),   32'(m_wq.size() < DEPTH));
        chk("rd_valid",   32'(rd_valid),   32'(m_rq.size() != 0));
        chk("rd_data",    32'(rd_data),    (m_rq.size() != 0) ? 32'(m_rq[0]) : 32'd0);
        chk("swap_pulse", 32'(swap_pulse), 32'(m_pulse));
        chk("wr_bank",    32'(wr_bank),    32'(m_bank));
`ifdef PINGPONG_SWAP_COUNT_EN
        chk("swap_count", 32'(swap_count), 32'(m_swaps));
`endif
    endtask

    // One clock cycle: check outputs, drive inputs, advance the model across the edge.
    task automatic step(input bit wv, input logic [WIDTH-1:0] wd, input bit rr);
        bit acc_w;
        bit acc_r;
        bit do_swap;
        check_outputs();
        wr_valid = wv;
        wr_data  = wd;
        rd_ready = rr;
        if (rd_valid && rr) out_log.push_back(rd_data);
        do_swap = (m_wq.size() == DEPTH) && (m_rq.size() == 0);
        acc_w   = wv && (m_wq.size() < DEPTH);
        acc_r   = rr && (m_rq.size() != 0);
        @(posedge clk);
        m_pulse   = do_swap;
        last_wacc = acc_w;
        if (acc_r) void'(m_rq.pop_front());
        if (acc_w) begin
            m_wq.push_back(wd);
            in_log.push_back(wd);
        end
        if (do_swap) begin
            m_rq = m_wq;
            m_wq.delete();
            m_bank  = ~m_bank;
            m_swaps = m_swaps + 16'd1;
        end
        @(negedge clk);
        #1;
    endtask

    task automatic write_word(input logic [WIDTH-1:0] d, input bit rr);
        for (int i = 0; i < 64; i++) begin
            step(1'b1, d, rr);
            if (last_wacc) return;
        end
        chk("wr_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n, input bit rr);
        for (int i = 0; i < n; i++) step(1'b0, WIDTH'($urandom), rr);
    endtask

    task automatic check_log(input string tag);
        chk({tag, "_count"}, 32'(out_log.size()), 32'(exp_log.size()));
        foreach (exp_log[i]) begin
            if (i < out_log.size()) chk(tag, 32'(out_log[i]), 32'(exp_log[i]));
        end
        out_log.delete();
        exp_log.delete();
        in_log.delete();
    endtask

    // Assert reset off-edge, check the cleared outputs right away, release on a falling edge.
    task automatic do_reset();
        rst      = 1'b1;
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        #1;
        chk("rst_wr_ready",   32'(wr_ready),   32'd0);
        chk("rst_rd_valid",   32'(rd_valid),   32'd0);
        chk("rst_rd_data",    32'(rd_data),    32'd0);
        chk("rst_swap_pulse", 32'(swap_pulse), 32'd0);
        chk("rst_wr_bank",    32'(wr_bank),    32'd0);
`ifdef PINGPONG_SWAP_COUNT_EN
        chk("rst_swap_count", 32'(swap_count), 32'd0);
`endif
        model_clear();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_wr_ready", 32'(wr_ready), 32'd1);
    endtask

    initial begin
        #3;
        do_reset();

        // Basic fill, swap and drain.
        for (int i = 0; i < 4; i++) write_word(WIDTH'(8'h11 * (i + 1)), 1'b1);
        idle(8, 1'b1);
        for (int i = 0; i < 4; i++) exp_log.push_back(WIDTH'(8'h11 * (i + 1)));
        chk("basic_wr_bank", 32'(wr_bank), 32'd1);
        chk("basic_rd_valid_end", 32'(rd_valid), 32'd0);
        check_log("basic_order");

        // Both banks full with the reader stalled, then released.
        for (int i = 0; i < 4; i++) write_word(WIDTH'(8'hA0 + i), 1'b0);
        for (int i = 0; i < 4; i++) write_word(WIDTH'(8'hB0 + i), 1'b0);
        idle(3, 1'b0);
        chk("stall_wr_ready_low", 32'(wr_ready), 32'd0);
        chk("stall_rd_valid", 32'(rd_valid), 32'd1);
        idle(14, 1'b1);
        for (int i = 0; i < 4; i++) exp_log.push_back(WIDTH'(8'hA0 + i));
        for (int i = 0; i < 4; i++) exp_log.push_back(WIDTH'(8'hB0 + i));
        check_log("stall_order");

        // Streaming: writer and reader both always active.
        for (int i = 0; i < 24; i++) step(1'b1, WIDTH'($urandom), 1'b1);
        idle(12, 1'b1);
        for (int i = 0; i < in_log.size() - m_wq.size(); i++) exp_log.push_back(in_log[i]);
        chk("stream_min_words", 32'(exp_log.size() >= 8), 32'd1);
        check_log("stream_order");

        // Reset in the middle of filling a bank.
        write_word(8'hC0, 1'b1);
        write_word(8'hC1, 1'b1);
        do_reset();
        for (int i = 0; i < 4; i++) write_word(WIDTH'(8'hD0 + i), 1'b1);
        idle(8, 1'b1);
        for (int i = 0; i < 4; i++) exp_log.push_back(WIDTH'(8'hD0 + i));
        check_log("midrst_order");

        // Random traffic, including writes offered while full and reads offered while empty.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), WIDTH'($urandom), ($urandom_range(0, 3) != 0));
        end
        idle(20, 1'b1);
        for (int i = 0; i < in_log.size() - m_wq.size(); i++) exp_log.push_back(in_log[i]);
        check_log("random_order");

`ifdef PINGPONG_SWAP_COUNT_EN
        // Counter wrap across three swaps, starting from a preloaded value.
        do_reset();
        dut.swap_cnt = 16'hFFFE;
        m_swaps      = 16'hFFFE;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 4; i++) write_word(WIDTH'($urandom), 1'b1);
            idle(6, 1'b1);
            chk("swap_count_wrap", 32'(swap_count), 32'(16'(16'hFFFF + r)));
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
